// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Pure definitions: no latency, no flow control.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic [1:0] {
    S_COUNT,
    S_WORDS,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream big-endian into 32-bit words; word_vld is combinational on the 4th byte.
// Zero added latency; no backpressure, every valid byte is consumed.
module word_assembler
  import loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [7:0]            byte_dat,
  input  logic                  byte_vld,
  output logic [WORD_WIDTH-1:0] word_dat,
  output logic                  word_vld
);

  // Only the three older bytes need storage; the newest is taken straight from the input.
  logic [WORD_WIDTH-9:0] shift_q;
  logic [1:0]            byte_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (byte_vld) begin
      shift_q    <= {shift_q[WORD_WIDTH-17:0], byte_dat};
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  assign word_dat = {shift_q, byte_dat};
  assign word_vld = byte_vld && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a count-prefixed big-endian word stream into instruction memory at addresses 0..N-1.
// Write strobe one cycle after the 4th byte of each word; no backpressure, bytes ignored once terminal.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int MEM_SIZE   = 20000,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic                  loading,
  output logic                  done,
  output logic                  error
);

  localparam logic [WORD_WIDTH-1:0] MEM_LIMIT = WORD_WIDTH'(MEM_SIZE);

  state_t                state_q, state_d, level_state;
  logic [WORD_WIDTH-1:0] count_q, word_index_q;
  logic [WORD_WIDTH-1:0] word_dat;
  logic                  word_vld;
  logic                  collecting, last_word;
  logic                  write_d, loading_d, done_d, error_d;

  assign collecting = (state_q == S_COUNT) || (state_q == S_WORDS);
  assign last_word  = (word_index_q == count_q - 32'd1);

  word_assembler u_word_assembler (
    .clk      (clk),
    .reset    (reset),
    .clear    (!collecting),
    .byte_dat (rx_data),
    .byte_vld (rx_valid && collecting),
    .word_dat (word_dat),
    .word_vld (word_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_COUNT;
      count_q      <= '0;
      word_index_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_COUNT && word_vld) begin
        count_q      <= word_dat;
        word_index_q <= '0;
      end else if (write_d) begin
        word_index_q <= word_index_q + 32'd1;
      end
    end
  end

  // Full 32-bit compare so oversized counts can never alias into range.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COUNT: begin
        if (word_vld) begin
          if (word_dat == '0)            state_d = S_DONE;
          else if (word_dat > MEM_LIMIT) state_d = S_ERROR;
          else                           state_d = S_WORDS;
        end
      end
      S_WORDS: begin
        if (word_vld && last_word) state_d = S_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // Status levels follow the next state, except that leaving S_WORDS shows up one
  // cycle late so done rises in the cycle after the final write strobe.
  always_comb begin
    write_d     = (state_q == S_WORDS) && word_vld;
    level_state = (state_q == S_WORDS) ? state_q : state_d;
    loading_d   = (level_state == S_COUNT) || (level_state == S_WORDS);
    done_d      = (level_state == S_DONE);
    error_d     = (level_state == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      loading          <= 1'b1;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      mem_write_enable <= write_d;
      if (write_d) begin
        mem_address    <= word_index_q[ADDR_WIDTH-1:0];
        mem_write_data <= word_dat;
      end
      loading <= loading_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader: stream model feeds a write scoreboard and a status-level timeline.
module tb_instruction_loader;

  localparam int MEM   = 512;
  localparam int AW    = 16;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          loading, done, error;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words_in[$];
  int          total    = 0;
  int          bad      = 0;
  int          cyc      = 0;
  int          lvl_now  = 0;   // 0 loading, 1 done, 2 error
  int          lvl_next = 0;
  int          lvl_at   = NEVER;
  bit          mon_en   = 1'b0;

  instruction_loader #(
    .MEM_SIZE   (MEM),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .loading          (loading),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [2:0] lvl_bits(int l);
    case (l)
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest expected write, at its due cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (mem_write_enable !== 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(mem_write_enable), 64'd0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_address), 64'(e.addr));
            check("wr_data", 64'(mem_write_data), 64'(e.data));
            check("wr_cycle", 64'(cyc), 64'(e.due));
          end
        end
        check("levels", 64'({loading, done, error}),
              64'(lvl_bits((cyc >= lvl_at) ? lvl_next : lvl_now)));
      end
    end
  end

  // Called at a negedge; asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    exp_q.delete();
    lvl_now  = 0;
    lvl_next = 0;
    lvl_at   = NEVER;
    #1;
    check("rst_we",      64'(mem_write_enable), 64'd0);
    check("rst_addr",    64'(mem_address),      64'd0);
    check("rst_data",    64'(mem_write_data),   64'd0);
    check("rst_loading", 64'(loading),          64'd1);
    check("rst_done",    64'(done),             64'd0);
    check("rst_error",   64'(error),            64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams count n followed by words_in; limit < 0 sends the whole stream.
  task automatic run_load(input logic [31:0] n, input int gmin, input int gmax, input int limit);
    logic [7:0] bytes[$];
    bit         valid_n;
    valid_n = (n != 32'd0) && (n <= 32'(MEM));
    for (int i = 0; i < 4; i++) bytes.push_back(n[31-8*i -: 8]);
    foreach (words_in[w])
      for (int i = 0; i < 4; i++) bytes.push_back(words_in[w][31-8*i -: 8]);
    for (int p = 0; p < bytes.size() && (limit < 0 || p < limit); p++) begin
      int dc;
      int k;
      int gap;
      dc       = cyc;
      rx_valid = 1'b1;
      rx_data  = bytes[p];
      if (p == 3) begin
        if (n == 32'd0) begin
          lvl_next = 1;
          lvl_at   = dc + 1;
        end else if (n > 32'(MEM)) begin
          lvl_next = 2;
          lvl_at   = dc + 1;
        end
      end
      if (valid_n && p >= 4 && (p - 4) % 4 == 3) begin
        k = (p - 4) / 4;
        if (k < int'(n)) begin
          wr_t e;
          e.addr = k;
          e.data = words_in[k];
          e.due  = dc + 1;
          exp_q.push_back(e);
          if (k == int'(n) - 1) begin
            lvl_next = 1;
            lvl_at   = dc + 2;
          end
        end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      gap = (gmax == 0) ? 0 : int'($urandom_range(gmax, gmin));
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    mon_en = 1'b1;

    words_in = '{32'h20080005, 32'h01095020};
    run_load(32'd2, 0, 0, -1);
    apply_reset();
    run_load(32'd2, 1, 50, -1);

    apply_reset();
    words_in = '{$urandom, $urandom};
    run_load(32'd0, 0, 0, -1);

    apply_reset();
    run_load(32'd20001, 0, 0, -1);
    apply_reset();
    run_load(32'(MEM + 1), 0, 2, -1);
    apply_reset();
    run_load(32'hFFFF_FFFF, 0, 0, -1);
    apply_reset();
    run_load(32'h0001_0002, 0, 0, -1);

    apply_reset();
    words_in.delete();
    for (int k = 0; k < MEM; k++) words_in.push_back(32'(k));
    run_load(32'(MEM), 0, 0, -1);

    for (int t = 0; t < 5; t++) begin
      int n;
      apply_reset();
      n = int'($urandom_range(20, 1));
      words_in.delete();
      for (int k = 0; k < n + 1; k++) words_in.push_back($urandom);
      run_load(32'(n), 0, 3, -1);
    end

    apply_reset();
    words_in = '{32'h20080005, 32'h01095020};
    run_load(32'd2, 0, 0, 6);
    apply_reset();
    words_in = '{32'hDEADBEEF};
    run_load(32'd1, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader feeding the instruction memory write port. Receives a byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and issues one write per word at consecutive word addresses starting at 0. Holds the CPU in load state until the declared word count has been written, then signals completion.

## Interface

- `MEM_SIZE`, default 20000: instruction memory depth in words; largest accepted word count.
- `ADDR_WIDTH`, default 16: width of `mem_address`; `MEM_SIZE` ≤ 2^`ADDR_WIDTH`.

Ports, clock and reset first:

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: `rx_data` valid this cycle. Every high cycle consumes one byte.
- `mem_write_enable`  out  1: one-cycle write strobe to instruction memory.
- `mem_address`  out  `ADDR_WIDTH`: word address of the current write.
- `mem_write_data`  out  32: instruction word to write.
- `loading`  out  1: load in progress; CPU must stay halted.
- `done`  out  1: level; all declared words written.
- `error`  out  1: level; declared count exceeds `MEM_SIZE`.

## Operation

- Stream format, all fields big-endian, first byte = bits [31:24]:
  - 4-byte word count N.
  - N words of 4 bytes each.
- States:
  - `S_COUNT`: collect 4 bytes into `count`.
    - 4th byte, N == 0 → `S_DONE`.
    - 4th byte, N > `MEM_SIZE` → `S_ERROR`.
    - Otherwise → `S_WORDS`, `word_index` = 0.
  - `S_WORDS`: collect 4 bytes.
    - On the 4th byte, register a write: address = `word_index`, data = assembled word.
    - Increment `word_index`.
    - After the write for `word_index` == N-1 → `S_DONE`.
  - `S_DONE`, `S_ERROR`: terminal until reset. `rx_valid` ignored; no writes.
- Byte assembly: `shift <= {shift[23:0], rx_data}`, with a 2-bit byte counter that wraps 3→0 at each word or count boundary.
- Comparisons use the full 32-bit `count`. N up to 2^32-1 must produce an error, never a truncated accept.
- `loading` = 1 in `S_COUNT` and `S_WORDS`; 0 otherwise.
- `done` = 1 only in `S_DONE`. `error` = 1 only in `S_ERROR`. Never both.
- Reset mid-load:
  - Returns to `S_COUNT` with the byte counter and `word_index` at 0.
  - Words already written to memory are not cleared.

## Timing

- Reset values:
  - `mem_write_enable` 0, `mem_address` 0, `mem_write_data` 0.
  - `loading` 1, `done` 0, `error` 0.
- All outputs are registered.
- Write latency:
  - 4th byte of a word sampled at edge t → `mem_write_enable` = 1 for exactly the cycle after t.
  - `mem_address` and `mem_write_data` are stable during that cycle; memory captures at edge t+1.
  - `mem_write_enable` = 0 in every other cycle.
- `mem_address` and `mem_write_data` hold their last values after the strobe.
- After the final write:
  - The state becomes `S_DONE` at the same edge as the write strobe.
  - `done` rises and `loading` falls in the cycle after the strobe.
- Count rejection: `error` or `done` (N == 0) rises in the cycle after the 4th count byte.
- Back-to-back bytes are supported (`rx_valid` high every cycle) with no stalls. No backpressure exists.
- Arbitrary gaps between bytes are allowed; there is no timeout.

## Structure

- Package `loader_pkg`:
  - State enum {`S_COUNT`, `S_WORDS`, `S_DONE`, `S_ERROR`}.
  - `BYTES_PER_WORD` = 4.
  - `WORD_WIDTH` = 32.
- Sub-module `word_assembler`:
  - Inputs: byte and valid. Synchronous clear.
  - Outputs: 32-bit word and a one-cycle `word_valid` on the 4th byte.
  - Used for both count and data collection.
- Top-level module holds the FSM, `count`, `word_index`, output registers and bound checks.

## Test plan

- Load N=2, bytes 00 00 00 02 20 08 00 05 01 09 50 20 back-to-back:
  - Writes (0, 0x20080005) then (1, 0x01095020), one-cycle strobes.
  - `done` = 1 and `loading` = 0 the cycle after the 2nd strobe.
- Same stream with random gaps of 1–50 idle cycles between bytes: identical writes and final state.
- N=0 (00 00 00 00), then extra bytes:
  - No strobe.
  - `done` = 1 the cycle after the 4th byte.
  - Extra bytes ignored.
- N=20001 (00 00 4E 21), then 8 bytes:
  - `error` = 1 the cycle after the 4th byte.
  - No writes; `loading` = 0.
  - N=0xFFFFFFFF also produces `error`.
- N=20000 with word k = k: last write at address 19999 with data 0x00004E1F, then `done` = 1.
- Reset asserted after 6 bytes of an N=2 load:
  - Outputs return to reset values immediately (asynchronously).
  - A fresh N=1 load of 0xDEADBEEF writes address 0 and reaches `done`.
